// File: rtl/error_decoder.sv
// rtl/error_decoder.sv - decodes the serial error line from its pulse width.
// Optional ERROR_DECODER_TIMESTAMP_EN adds a free-running ts counter and the err_ts output.
module error_decoder #(
  parameter int ERROR_LENGTH = 3,
  parameter int SYNC_STAGES  = 2,
  parameter int STUCK_LIMIT  = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 err_in,
  input  logic                 clear,
  output logic                 err_valid,
  output logic [1:0]           err_level,
  output logic                 error_sticky,
  output logic                 stop_active,
  output logic                 line_stuck,
  output logic [CNT_WIDTH-1:0] err_cnt,
  output logic [CNT_WIDTH-1:0] stop_cnt,
  output logic [CNT_WIDTH-1:0] warn_cnt,
  output logic [CNT_WIDTH-1:0] bad_cnt
`ifdef ERROR_DECODER_TIMESTAMP_EN
  ,
  output logic [31:0]          err_ts
`endif
);

  localparam int WW = $clog2(STUCK_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, HIGH, DECODE} state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s_in;
  state_t                 state;
  logic [WW-1:0]          width;
  logic [1:0]             lvl;
  logic                   dec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[SYNC_STAGES-2:0], err_in};
  end

  assign s_in = sync[SYNC_STAGES-1];
  assign dec  = (state == DECODE);

  // Any width outside 1..ERROR_LENGTH is not a legal encoder symbol.
  always_comb begin
    lvl = 2'd3;
    if (width >= WW'(1) && width <= WW'(ERROR_LENGTH))
      lvl = 2'(width - 1'b1);
  end

  function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] v, input logic hit);
    return (hit && v != {CNT_WIDTH{1'b1}}) ? v + 1'b1 : v;
  endfunction

`ifdef ERROR_DECODER_TIMESTAMP_EN
  logic [31:0] ts;
  logic [31:0] ts_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts <= '0;
    else        ts <= ts + 32'd1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      width        <= '0;
      err_valid    <= 1'b0;
      err_level    <= 2'd0;
      error_sticky <= 1'b0;
      stop_active  <= 1'b0;
      line_stuck   <= 1'b0;
      err_cnt      <= '0;
      stop_cnt     <= '0;
      warn_cnt     <= '0;
      bad_cnt      <= '0;
`ifdef ERROR_DECODER_TIMESTAMP_EN
      ts_start     <= '0;
      err_ts       <= '0;
`endif
    end else begin
      err_valid <= dec;
      if (dec) err_level <= lvl;
`ifdef ERROR_DECODER_TIMESTAMP_EN
      if (dec) err_ts <= ts_start;
`endif

      // clear acts first so an event decoded in the same cycle still lands.
      err_cnt      <= bump(clear ? '0 : err_cnt,  dec && lvl == 2'd0);
      stop_cnt     <= bump(clear ? '0 : stop_cnt, dec && lvl == 2'd1);
      warn_cnt     <= bump(clear ? '0 : warn_cnt, dec && lvl == 2'd2);
      bad_cnt      <= bump(clear ? '0 : bad_cnt,  dec && lvl == 2'd3);
      error_sticky <= (error_sticky && !clear) || (dec && (lvl == 2'd0 || lvl == 2'd3));
      stop_active  <= (stop_active && !clear) ^ (dec && lvl == 2'd1);

      case (state)
        IDLE: begin
          if (s_in) begin
            state <= HIGH;
            width <= WW'(1);
`ifdef ERROR_DECODER_TIMESTAMP_EN
            ts_start <= ts;
`endif
          end
        end
        HIGH: begin
          if (s_in) begin
            if (width != WW'(STUCK_LIMIT)) width <= width + 1'b1;
            if (width >= WW'(STUCK_LIMIT - 1)) line_stuck <= 1'b1;
          end else begin
            state <= DECODE;
          end
        end
        DECODE: begin
          line_stuck <= 1'b0;
          // A pulse may start right after the decoded one with no idle gap.
          if (s_in) begin
            state <= HIGH;
            width <= WW'(1);
`ifdef ERROR_DECODER_TIMESTAMP_EN
            ts_start <= ts;
`endif
          end else begin
            state <= IDLE;
            width <= '0;
          end
        end
        default: begin
          state <= IDLE;
          width <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_error_decoder.sv
// tb/tb_error_decoder.sv - directed self-checking bench for error_decoder.
module tb_error_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        err_in = 1'b0;
  logic        clear = 1'b0;
  logic        err_valid;
  logic [1:0]  err_level;
  logic        error_sticky, stop_active, line_stuck;
  logic [15:0] err_cnt, stop_cnt, warn_cnt, bad_cnt;
  logic        s_valid, s_sticky, s_stop, s_stuck;
  logic [1:0]  s_level;
  logic [1:0]  s_err, s_stopc, s_warn, s_bad;
`ifdef ERROR_DECODER_TIMESTAMP_EN
  logic [31:0] err_ts, s_ts;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  error_decoder dut (
    .clk(clk), .rst_n(rst_n), .err_in(err_in), .clear(clear),
    .err_valid(err_valid), .err_level(err_level), .error_sticky(error_sticky),
    .stop_active(stop_active), .line_stuck(line_stuck),
    .err_cnt(err_cnt), .stop_cnt(stop_cnt), .warn_cnt(warn_cnt), .bad_cnt(bad_cnt)
`ifdef ERROR_DECODER_TIMESTAMP_EN
    , .err_ts(err_ts)
`endif
  );

  // Narrow-counter copy on the same stimulus, used to reach counter saturation.
  error_decoder #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .err_in(err_in), .clear(clear),
    .err_valid(s_valid), .err_level(s_level), .error_sticky(s_sticky),
    .stop_active(s_stop), .line_stuck(s_stuck),
    .err_cnt(s_err), .stop_cnt(s_stopc), .warn_cnt(s_warn), .bad_cnt(s_bad)
`ifdef ERROR_DECODER_TIMESTAMP_EN
    , .err_ts(s_ts)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends an n-cycle high pulse, then reports strobe latency (steps after the drive
  // went low, 0 on timeout), the decoded level and err_valid one cycle later.
  task automatic pulse(input int n, output int lat, output logic [1:0] lvl, output logic nxt);
    err_in = 1'b1;
    repeat (n) step();
    err_in = 1'b0;
    lat = 0;
    lvl = 2'd0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (err_valid) begin
        lat = i;
        lvl = err_level;
        break;
      end
    end
    step();
    nxt = err_valid;
    repeat (3) step();
  endtask

  int         lat;
  logic [1:0] lvl;
  logic       nxt;
  int         strobes;

  initial begin
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check_eq("reset_flags", {err_valid, err_level, error_sticky, stop_active, line_stuck}, 0);
    check_eq("reset_cnts", {err_cnt, stop_cnt}, 0);
    check_eq("reset_cnts2", {warn_cnt, bad_cnt}, 0);

    pulse(1, lat, lvl, nxt);
    check_eq("err_latency", lat, 4);
    check_eq("err_level", lvl, 0);
    check_eq("err_one_shot", nxt, 0);
    check_eq("err_cnt", err_cnt, 1);
    check_eq("err_sticky", error_sticky, 1);

    pulse(2, lat, lvl, nxt);
    check_eq("stop1_level", lvl, 1);
    check_eq("stop1_active", stop_active, 1);
    pulse(3, lat, lvl, nxt);
    check_eq("warn_level", lvl, 2);
    check_eq("warn_latency", lat, 4);
    pulse(2, lat, lvl, nxt);
    check_eq("stop2_level", lvl, 1);
    check_eq("stop2_active", stop_active, 0);
    check_eq("stop_cnt", stop_cnt, 2);
    check_eq("warn_cnt", warn_cnt, 1);

    clear = 1'b1;
    step();
    clear = 1'b0;
    check_eq("clear_sticky", {error_sticky, err_cnt}, 0);
    pulse(5, lat, lvl, nxt);
    check_eq("bad_level", lvl, 3);
    check_eq("bad_cnt", bad_cnt, 1);
    check_eq("bad_sticky", error_sticky, 1);

    // Stuck line: line_stuck follows the 16th synchronized high cycle (edge 18).
    err_in = 1'b1;
    repeat (17) step();
    check_eq("stuck_before", line_stuck, 0);
    step();
    check_eq("stuck_at_limit", line_stuck, 1);
    repeat (2) step();
    err_in = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (err_valid) begin
        lat = i;
        break;
      end
    end
    check_eq("stuck_latency", lat, 4);
    check_eq("stuck_level", err_level, 3);
    check_eq("stuck_cleared", line_stuck, 0);
    check_eq("stuck_bad_cnt", bad_cnt, 2);
    repeat (4) step();

    // Back-to-back 2-high/1-low/1-high, clear during the second DECODE cycle.
    clear = 1'b1;
    step();
    clear = 1'b0;
    strobes = 0;
    err_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 2) err_in = 1'b0;
      if (k == 3) err_in = 1'b1;
      if (k == 4) err_in = 1'b0;
      if (err_valid) strobes++;
      if (k == 6) begin
        check_eq("b2b_first", {err_valid, err_level}, 3'b101);
        check_eq("b2b_stop_on", stop_active, 1);
      end
      if (k == 7) clear = 1'b1;
      if (k == 8) begin
        clear = 1'b0;
        check_eq("b2b_second", {err_valid, err_level}, 3'b100);
        check_eq("b2b_cnts", {err_cnt, stop_cnt}, {16'd1, 16'd0});
        check_eq("b2b_stop_off", stop_active, 0);
      end
    end
    check_eq("b2b_strobes", strobes, 2);

    // Counter saturation on the 2-bit copy: 5 warnings stop at 3.
    clear = 1'b1;
    step();
    clear = 1'b0;
    pulse(3, lat, lvl, nxt);
    pulse(3, lat, lvl, nxt);
    check_eq("sat_warn2", s_warn, 2);
    pulse(3, lat, lvl, nxt);
    check_eq("sat_warn3", s_warn, 3);
    pulse(3, lat, lvl, nxt);
    pulse(3, lat, lvl, nxt);
    check_eq("sat_warn_hold", s_warn, 3);
    check_eq("sat_main_warn", warn_cnt, 5);

    // Reset in the second cycle of a 3-cycle pulse.
    err_in = 1'b1;
    step();
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_flags", {err_valid, err_level, error_sticky, stop_active, line_stuck}, 0);
    check_eq("rst_mid_cnts", {warn_cnt, bad_cnt, err_cnt, stop_cnt}, 0);
    #1;
    rst_n = 1'b1;
    step();
    step();
    err_in = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (err_valid) begin
        lat = i;
        break;
      end
    end
    check_eq("rst_tail_latency", lat, 4);
    check_eq("rst_tail_level", err_level, 1);
    check_eq("rst_tail_cnts", {stop_cnt, err_cnt}, {16'd1, 16'd0});
    check_eq("rst_tail_flags", {error_sticky, stop_active}, 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/error_decoder.md
Name: error_decoder

Overview:
- Receive-side stage directly downstream of the front-end error coder: it consumes the single-wire serial error line and recovers the error class from the pulse width.
- Encoding on the line: ERROR = 1-cycle high, STOP = 2-cycle high, WARNING = 3-cycle high, each followed by low for the rest of a window of ERROR_LENGTH+1 cycles.
- Outputs a one-cycle decoded event, per-class saturating counters, a sticky fatal flag and a STOP-state tracker for the trigger/DAQ control logic.

Parameters:
ERROR_LENGTH, 3, encoder window length; longest legal high pulse = ERROR_LENGTH cycles
SYNC_STAGES, 2, flip-flop synchronizer depth on err_in (min 2)
STUCK_LIMIT, 16, high-width in cycles at which line_stuck asserts
CNT_WIDTH, 16, width of each event counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
err_in  in  1  serial error line from error coder (may be asynchronous)
clear  in  1  synchronous pulse: zero counters, error_sticky, stop_active
err_valid  out  1  one-cycle strobe, decoded event present
err_level  out  2  0=ERROR, 1=STOP, 2=WARNING, 3=MALFORMED; held until next err_valid
error_sticky  out  1  set by ERROR or MALFORMED, cleared only by clear/reset
stop_active  out  1  toggles on every STOP event (rising/falling of encoder STOP)
line_stuck  out  1  err_in high for >= STUCK_LIMIT cycles
err_cnt  out  CNT_WIDTH  ERROR count
stop_cnt  out  CNT_WIDTH  STOP count
warn_cnt  out  CNT_WIDTH  WARNING count
bad_cnt  out  CNT_WIDTH  MALFORMED count

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM to IDLE, synchronizer chain 0, width counter 0.
- err_in passes through SYNC_STAGES flops; the last stage (s_in) is the only internal use of the line.
- Width counter: clog2(STUCK_LIMIT+1) bits, saturates at STUCK_LIMIT.
- FSM IDLE: s_in=1 -> HIGH, width=1; else stay.
- FSM HIGH: s_in=1 -> width+1 (saturating), stay; s_in=0 -> DECODE.
- FSM DECODE, one cycle:
  - err_valid=1.
  - err_level = width-1 for 1<=width<=ERROR_LENGTH, else 3.
  - Increment the matching counter.
  - Then -> IDLE if s_in=0; if s_in=1 -> HIGH with width=1 (back-to-back pulse, no gap required).
- Latency: err_valid asserts SYNC_STAGES+1 cycles after the first low sample of err_in.
- line_stuck: set when width reaches STUCK_LIMIT in HIGH; cleared in the DECODE cycle. A stuck pulse decodes as MALFORMED only when it ends.
- error_sticky set in DECODE when level is 0 or 3. stop_active inverts in DECODE when level is 1.
- Counters saturate at 2^CNT_WIDTH-1; no wrap.
- clear in the same cycle as DECODE: clear first, then the new event applies, e.g. err_cnt=1, error_sticky=1. clear never disturbs the FSM, width counter or line_stuck.
- A WARNING restarted by an ERROR mid-pulse at the encoder yields one merged high pulse; the decoder classifies it purely by total width (MALFORMED if >ERROR_LENGTH). No attempt is made to split it.
- Reset asserted mid-pulse: everything is cleared immediately. The remainder of that pulse after release is decoded by width as seen from release.

Optional Feature:
ERROR_DECODER_TIMESTAMP_EN
- Defined:
  - Adds a free-running 32-bit cycle counter ts, cleared by reset only.
  - Adds output err_ts[31:0]: value of ts in the cycle the FSM enters HIGH, presented with err_valid and held until the next err_valid.
  - Back-to-back pulses latch a fresh value.
- Undefined: counter and err_ts port are absent; all other behaviour is identical.

Test Plan:
- Reset, then single 1-cycle err_in pulse -> err_valid once at cycle SYNC_STAGES+1 after the falling edge, err_level=0, err_cnt=1, error_sticky=1.
- Pulses of 2, 3, then 2 cycles with 4-cycle gaps -> levels 1,2,1; stop_cnt=2, warn_cnt=1, stop_active 0->1->0.
- 5-cycle pulse -> err_level=3, bad_cnt=1, error_sticky=1. 20-cycle pulse -> line_stuck high from cycle 16 of the high until DECODE, then MALFORMED.
- 2-cycle high, 1-cycle low, 1-cycle high -> two err_valid strobes with levels 1 then 0. clear coincident with the second strobe -> err_cnt=1, stop_cnt=0, stop_active=0.
- Force warn_cnt to 16'hFFFE and send 3 WARNING pulses -> warn_cnt stays 16'hFFFF.
- Drop rst_n during the 2nd cycle of a 3-cycle pulse -> all outputs 0 immediately. After release the remaining high decodes with reduced width and no leftover state.
